// File: rtl/display_arb_pkg.sv
// display_arb_pkg
// Shared definitions for the display port arbiter: FSM state encoding,
// grant index constants and the timeout counter width.
package display_arb_pkg;

  localparam int CNT_W = 16;

  localparam logic GRANT_TIME = 1'b0;
  localparam logic GRANT_CFG  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_DONE     = 2'd3
  } arb_state_t;

endpackage

// File: rtl/arb_timeout.sv
// arb_timeout
// 16-bit up-counter that measures how long the arbiter has waited for the
// display to acknowledge a frame.
// Ports:
//   i_clk, i_reset_n : clock, async active-low reset
//   i_clr            : synchronous clear (wins over enable)
//   i_en             : count one cycle
//   o_expired        : count has reached TIMEOUT_CYCLES-1
module arb_timeout #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  import display_arb_pkg::*;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count <= '0;
    end else if (i_clr) begin
      count <= '0;
    end else if (i_en) begin
      count <= count + 1'b1;
    end
  end

  assign o_expired = (count == LIMIT);

endmodule

// File: rtl/display_arbiter.sv
// display_arbiter
// Shares the output_wrapper display port between the config requester and
// the time-refresh requester. Requests are latched and coalesced into one
// pending flag each, granted round-robin, and a stuck display is abandoned
// after TIMEOUT_CYCLES with the request left pending for retry.
// Ports:
//   i_clk, i_reset_n          : clock, async active-low reset
//   i_cfg_stb / o_cfg_ack     : config write request / completion pulse
//   i_time_stb / o_time_ack   : time refresh request / completion pulse
//   o_display_stb             : one-cycle start strobe to output_wrapper
//   o_write_config            : frame select (1 = config), held per transaction
//   i_display_busy            : output_wrapper busy, gates new grants
//   i_display_ack             : output_wrapper completion pulse
//   o_busy                    : arbiter not idle
//   o_timeout                 : one-cycle pulse on a timeout abort
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a pending flag and a non-busy display
// ISSUE     | grant made; strobe to the display is launched
// WAIT_ACK  | waiting for the display ack, timeout counter running
// DONE      | ack received; pulse requester ack and clear its flag
module display_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CFG_ON_RESET   = 1
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_cfg_stb,
  output logic o_cfg_ack,
  input  logic i_time_stb,
  output logic o_time_ack,
  output logic o_display_stb,
  output logic o_write_config,
  input  logic i_display_busy,
  input  logic i_display_ack,
  output logic o_busy,
  output logic o_timeout
);
  import display_arb_pkg::*;

  localparam logic PEND_CFG_RST = (CFG_ON_RESET != 0);

  arb_state_t state, state_nxt;
  logic       pend_cfg, pend_time;
  logic       last_grant;
  logic       grant_sel;
  logic       take_grant;
  logic       tmo_clr, tmo_abort, tmo_expired;
  logic       done_cfg, done_time;

  arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clr     (tmo_clr),
    .i_en      (state == ST_WAIT_ACK),
    .o_expired (tmo_expired)
  );

  always_comb begin
    state_nxt  = state;
    grant_sel  = last_grant;
    take_grant = 1'b0;
    tmo_clr    = 1'b0;
    tmo_abort  = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((pend_cfg || pend_time) && !i_display_busy) begin
          take_grant = 1'b1;
          state_nxt  = ST_ISSUE;
          if (pend_cfg && pend_time) begin
            grant_sel = ~last_grant;
          end else begin
            grant_sel = pend_cfg ? GRANT_CFG : GRANT_TIME;
          end
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        // An ack on the expiry cycle still counts as a success.
        if (i_display_ack) begin
          state_nxt = ST_DONE;
        end else if (tmo_expired) begin
          state_nxt = ST_IDLE;
          tmo_abort = 1'b1;
          tmo_clr   = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        tmo_clr   = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // last_grant is registered at grant time, so it names the requester
  // currently being served for the rest of the transaction.
  assign done_cfg  = (state == ST_DONE) && (last_grant == GRANT_CFG);
  assign done_time = (state == ST_DONE) && (last_grant == GRANT_TIME);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= ST_IDLE;
      pend_cfg       <= PEND_CFG_RST;
      pend_time      <= 1'b0;
      last_grant     <= GRANT_TIME;
      o_write_config <= 1'b0;
      o_display_stb  <= 1'b0;
      o_cfg_ack      <= 1'b0;
      o_time_ack     <= 1'b0;
      o_timeout      <= 1'b0;
    end else begin
      state <= state_nxt;
      // A strobe coinciding with the clear re-arms the flag.
      pend_cfg  <= i_cfg_stb  | (pend_cfg  & ~done_cfg);
      pend_time <= i_time_stb | (pend_time & ~done_time);
      if (take_grant) begin
        last_grant     <= grant_sel;
        o_write_config <= (grant_sel == GRANT_CFG);
      end
      o_display_stb <= (state == ST_ISSUE);
      o_cfg_ack     <= done_cfg;
      o_time_ack    <= done_time;
      o_timeout     <= tmo_abort;
    end
  end

  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_display_arbiter.sv
module tb_display_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic cfg_stb = 1'b0, time_stb = 1'b0, disp_busy = 1'b0;
  logic resp_ack = 1'b0, stray_ack = 1'b0;
  logic disp_ack;
  logic cfg_ack, time_ack, disp_stb, write_cfg, busy, tmo;

  assign disp_ack = resp_ack | stray_ack;

  display_arbiter #(
    .TIMEOUT_CYCLES(16),
    .CFG_ON_RESET  (1)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_cfg_stb      (cfg_stb),
    .o_cfg_ack      (cfg_ack),
    .i_time_stb     (time_stb),
    .o_time_ack     (time_ack),
    .o_display_stb  (disp_stb),
    .o_write_config (write_cfg),
    .i_display_busy (disp_busy),
    .i_display_ack  (disp_ack),
    .o_busy         (busy),
    .o_timeout      (tmo)
  );

  int total = 0;
  int bad   = 0;

  // Pulse counters and a log of the frame select seen with each strobe.
  int   n_stb = 0, n_cfg = 0, n_time = 0, n_tmo = 0;
  logic wc_log [64];
  int   b_stb, b_cfg, b_time, b_tmo;

  always @(negedge clk) begin
    if (disp_stb) begin
      if (n_stb < 64) wc_log[n_stb] <= write_cfg;
      n_stb <= n_stb + 1;
    end
    if (cfg_ack)  n_cfg  <= n_cfg + 1;
    if (time_ack) n_time <= n_time + 1;
    if (tmo)      n_tmo  <= n_tmo + 1;
  end

  // Display model: acks ack_dly cycles after seeing a strobe, when enabled.
  logic ack_en  = 1'b1;
  int   ack_dly = 2;
  initial begin
    forever begin
      @(negedge clk);
      if (disp_stb && ack_en) begin
        repeat (ack_dly) @(posedge clk);
        #1 resp_ack = 1'b1;
        @(posedge clk);
        #1 resp_ack = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_stb  = n_stb;
    b_cfg  = n_cfg;
    b_time = n_time;
    b_tmo  = n_tmo;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs", {26'd0, disp_stb, cfg_ack, time_ack, tmo, busy, write_cfg}, 32'd0);
    repeat (3) step();
    rst_n = 1'b1;

    // Config armed out of reset is the first transaction
    snap();
    step(); step();
    chk("boot_stb", disp_stb, 1);
    chk("boot_wc", write_cfg, 1);
    repeat (4) step();
    chk("boot_cfg_ack", cfg_ack, 1);
    chk("boot_busy_low", busy, 0);
    step();
    chk("boot_cfg_ack_once", n_cfg - b_cfg, 1);
    chk("boot_no_time_ack", n_time - b_time, 0);

    // Both requests together with last grant = config: time goes first
    snap();
    cfg_stb = 1'b1; time_stb = 1'b1;
    step();
    cfg_stb = 1'b0; time_stb = 1'b0;
    repeat (25) step();
    chk("both_stb_count", n_stb - b_stb, 2);
    chk("both_first_wc", wc_log[b_stb], 0);
    chk("both_second_wc", wc_log[b_stb + 1], 1);
    chk("both_cfg_acks", n_cfg - b_cfg, 1);
    chk("both_time_acks", n_time - b_time, 1);

    // Single time request latency, plus a strobe on the clearing cycle
    snap();
    time_stb = 1'b1;
    step();
    time_stb = 1'b0;
    chk("time_stb_n0", disp_stb, 0);
    step();
    chk("time_stb_n1", disp_stb, 0);
    step();
    chk("time_stb_n2", disp_stb, 1);
    chk("time_wc", write_cfg, 0);
    step(); step(); step();
    time_stb = 1'b1;
    step();
    time_stb = 1'b0;
    chk("time_ack_edge", time_ack, 1);
    repeat (12) step();
    chk("rearm_time_acks", n_time - b_time, 2);
    chk("rearm_stb_count", n_stb - b_stb, 2);
    chk("time_no_cfg_ack", n_cfg - b_cfg, 0);

    // Stray ack in ISSUE is ignored; no ack leads to timeout and retry
    snap();
    ack_en = 1'b0;
    time_stb = 1'b1;
    step();
    time_stb = 1'b0;
    step();
    stray_ack = 1'b1;
    step();
    stray_ack = 1'b0;
    chk("tmo_stb", disp_stb, 1);
    repeat (15) step();
    chk("tmo_not_yet", tmo, 0);
    step();
    chk("tmo_pulse", tmo, 1);
    chk("stray_ignored", n_time - b_time, 0);
    ack_en = 1'b1;
    step(); step();
    chk("retry_stb", disp_stb, 1);
    chk("retry_wc", write_cfg, 0);
    repeat (8) step();
    chk("retry_time_ack", n_time - b_time, 1);
    chk("tmo_count", n_tmo - b_tmo, 1);

    // Busy display holds off the grant, no timeout accrues
    snap();
    disp_busy = 1'b1;
    time_stb = 1'b1;
    step();
    time_stb = 1'b0;
    repeat (30) step();
    chk("busy_no_stb", n_stb - b_stb, 0);
    chk("busy_no_tmo", n_tmo - b_tmo, 0);
    chk("busy_idle", busy, 0);
    disp_busy = 1'b0;
    repeat (12) step();
    chk("busy_release_ack", n_time - b_time, 1);

    // Five time strobes merged during one config transaction
    snap();
    ack_dly = 8;
    cfg_stb = 1'b1;
    step();
    cfg_stb = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      time_stb = 1'b1;
      step();
      time_stb = 1'b0;
      step();
    end
    repeat (30) step();
    ack_dly = 2;
    chk("merge_stb_count", n_stb - b_stb, 2);
    chk("merge_first_wc", wc_log[b_stb], 1);
    chk("merge_second_wc", wc_log[b_stb + 1], 0);
    chk("merge_cfg_acks", n_cfg - b_cfg, 1);
    chk("merge_time_acks", n_time - b_time, 1);

    // Async reset during WAIT_ACK, then config write reissued
    snap();
    ack_en = 1'b0;
    cfg_stb = 1'b1;
    step();
    cfg_stb = 1'b0;
    step(); step();
    chk("rst_pre_stb", disp_stb, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {26'd0, disp_stb, cfg_ack, time_ack, tmo, busy, write_cfg}, 32'd0);
    step(); step();
    ack_en = 1'b1;
    rst_n = 1'b1;
    step(); step();
    chk("rst_reissue_stb", disp_stb, 1);
    chk("rst_reissue_wc", write_cfg, 1);
    repeat (8) step();
    chk("rst_reissue_ack", n_cfg - b_cfg, 1);
    chk("rst_final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
